// File: rtl/nibble_serial_addsub_pkg.sv
// Shared constants for the nibble-serial add/subtract unit: FSM encoding and slice geometry.
// No timing or handshake behaviour lives here.
package nibble_serial_addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // A single-nibble configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Operand request / result bundle between source, add/sub unit and consumer.
// Both directions use valid/ready; data is qualified only by the matching valid.
interface nibble_serial_addsub_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );

endinterface

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple adder built from full-adder cells; zero latency, no handshake.
// B is expected pre-inverted by the caller for subtraction.
module nibble_add_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  always_comb begin : ripple
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Serial add/subtract, one nibble per cycle through a single 4-bit slice; result valid NIBBLES cycles after accept.
// Result and flags hold in DONE until out_ready; no new request is accepted until the cycle after the result handshake.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_addsub_if.slave  bus
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_next;
  logic          carry_q;
  logic          carry_out_q;
  logic          overflow_q;
  logic          zero_q;

  logic [3:0]    slice_a;
  logic [3:0]    slice_b;
  logic [3:0]    slice_sum;
  logic          slice_cout;
  logic          last;

  assign slice_a = a_q[NIBBLE_W*idx +: NIBBLE_W];
  assign slice_b = b_q[NIBBLE_W*idx +: NIBBLE_W];
  assign last    = (idx == LAST_IDX);

  nibble_add_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Full result as it will look after this edge, so zero sees the final nibble.
  always_comb begin
    res_next = res_q;
    res_next[NIBBLE_W*idx +: NIBBLE_W] = slice_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {W{bus.sub}};
            carry_q <= bus.sub;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q   <= res_next;
          carry_q <= slice_cout;
          if (last) begin
            idx         <= '0;
            state       <= ST_DONE;
            carry_out_q <= slice_cout;
            // Carry into the MSB is recovered from the MSB sum bit of the final slice.
            overflow_q  <= (a_q[W-1] ^ b_q[W-1] ^ slice_sum[3]) ^ slice_cout;
            zero_q      <= (res_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed corner vectors, backpressure, mid-run reset, back-to-back and random operations.
// Expected values come from constants and a signed/unsigned arithmetic reference model.
module tb_nibble_serial_addsub;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_addsub_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint m, h, ua, ub, sa, sb, t;
    m  = longint'(1) << W;
    h  = m >> 1;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    if (s) begin
      e.co  = (ua >= ub);
      e.res = W'(ua - ub);
      t     = sa - sb;
    end else begin
      e.co  = ((ua + ub) >= m);
      e.res = W'(ua + ub);
      t     = sa + sb;
    end
    e.ov = (t >= h) || (t < -h);
    e.z  = (e.res == '0);
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.res = bus.result;
    o.co  = bus.carry_out;
    o.ov  = bus.overflow;
    o.z   = bus.zero;
    return o;
  endfunction

  // Drive a request and return at the negedge right after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int waited;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack(output logic ov_after, output logic ir_after);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ov_after      = bus.out_valid;
    ir_after      = bus.in_ready;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 16'h1111;
    bus.b        = 16'h0001;
    bus.sub      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.result !== '0 || {bus.carry_out, bus.overflow, bus.zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_data: result=%h flags=%b%b%b, want 0000 000",
               bus.result, bus.carry_out, bus.overflow, bus.zero);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  logic [W-1:0] da [5] = '{16'h1234, 16'h0005, 16'h7FFF, 16'hFFFF, 16'h8000};
  logic [W-1:0] db [5] = '{16'h0FCD, 16'h0007, 16'h0001, 16'h0001, 16'h8000};
  logic         ds [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] dr [5] = '{16'h2201, 16'hFFFE, 16'h8000, 16'h0000, 16'h0000};
  logic [2:0]   df [5] = '{3'b000, 3'b000, 3'b010, 3'b101, 3'b101};

  task automatic test_directed;
    int   lat;
    logic ova, ira;
    for (int i = 0; i < 5; i++) begin
      start_op(da[i], db[i], ds[i]);
      wait_done(lat);
      checks++;
      if (lat !== NIBBLES) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d cycles, want %0d", i, lat, NIBBLES);
      end
      checks++;
      if (bus.result !== dr[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got %h, want %h", i, bus.result, dr[i]);
      end
      checks++;
      if ({bus.carry_out, bus.overflow, bus.zero} !== df[i]) begin
        errors++;
        $display("FAIL dir%0d_flags: got co/ov/z=%b%b%b, want %b",
                 i, bus.carry_out, bus.overflow, bus.zero, df[i]);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_ready_in_done: got %b, want 0", i, bus.in_ready);
      end
      ack(ova, ira);
      checks++;
      if (ova !== 1'b0 || ira !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_after_ack: out_valid=%b in_ready=%b, want 0 1", i, ova, ira);
      end
    end
  endtask

  task automatic test_backpressure;
    int   lat;
    logic ova, ira;
    exp_t e;
    e = model(16'hA5A5, 16'h1111, 1'b1);
    start_op(16'hA5A5, 16'h1111, 1'b1);
    wait_done(lat);
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'hFFFF;
      bus.b        = 16'hFFFF;
      bus.sub      = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d_handshake: out_valid=%b in_ready=%b, want 1 0", c, bus.out_valid, bus.in_ready);
      end
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL bp_hold%0d_data: got %h, want %h", c, observed(), e);
      end
    end
    bus.in_valid = 1'b0;
    ack(ova, ira);
    checks++;
    if (ova !== 1'b0 || ira !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", ova, ira);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored_request: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_run;
    int   lat;
    logic seen;
    logic ova, ira;
    start_op(16'h4321, 16'h1234, 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0 ||
        {bus.carry_out, bus.overflow, bus.zero} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_outputs: in_ready=%b out_valid=%b result=%h flags=%b%b%b, want 1 0 0000 000",
               bus.in_ready, bus.out_valid, bus.result, bus.carry_out, bus.overflow, bus.zero);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_result: out_valid pulse seen=%b, want 0", seen);
    end
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== NIBBLES || bus.result !== 16'h0002) begin
      errors++;
      $display("FAIL midrst_next_op: latency=%0d result=%h, want %0d 0002", lat, bus.result, NIBBLES);
    end
    ack(ova, ira);
  endtask

  task automatic test_back_to_back;
    int   acc_cyc [$];
    exp_t expq [$];
    exp_t e;
    int   nops;
    int   nres;
    logic [W-1:0] ra, rb;
    logic rs;
    nops = 0;
    nres = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.out_valid && expq.size() > 0) begin
        e = expq.pop_front();
        nres++;
        checks++;
        if (observed() !== e) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h, want %h", nres, observed(), e);
        end
      end
      if (bus.in_ready && nops < 3) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rs = 1'($urandom_range(0, 1));
        bus.a = ra;
        bus.b = rb;
        bus.sub = rs;
        bus.in_valid = 1'b1;
        expq.push_back(model(ra, rb, rs));
        acc_cyc.push_back(cyc);
        nops++;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (nres !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, want 3", nres);
    end
    for (int k = 1; k < acc_cyc.size(); k++) begin
      checks++;
      if (acc_cyc[k] - acc_cyc[k-1] !== NIBBLES + 2) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d cycles, want %0d", k, acc_cyc[k] - acc_cyc[k-1], NIBBLES + 2);
      end
    end
  endtask

  task automatic test_random;
    int           lat;
    logic         ova, ira;
    logic [W-1:0] ra, rb;
    logic         rs;
    exp_t         e;
    logic [W-1:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    for (int i = 0; i < 40; i++) begin
      ra = (i < 8) ? corner[i % 4] : W'($urandom);
      rb = (i < 8) ? corner[(i / 2) % 4] : W'($urandom);
      rs = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rs);
      start_op(ra, rb, rs);
      wait_done(lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL rand%0d: %h %s %h got res/co/ov/z=%h, want %h",
                 i, ra, rs ? "-" : "+", rb, observed(), e);
      end
      ack(ova, ira);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
